class_sum_accumulator: RTL and testbench
========================================

// Module: class_sum_accumulator
// PURPOSE
//  Upstream feeder of the 10-class max comparator. Consumes the final conv layer's
//  N_MATS feature maps as a stream, one pixel of every map per beat.
//  Reduces each map to one score (sum, or mean with AVG_POOL_EN) and presents all
//  N_MATS scores in parallel, as unsigned DATA_WIDTH values, for the comparator's sum[] input.
// PARAMETERS
//  DATA_WIDTH   16  width of each input pixel (signed) and each output score (unsigned)
//  N_MATS       10  number of feature maps / classes (parallel lanes)
//  PIX_PER_MAP  16  beats per frame (pixels per map); must be >= 2
//  ACC_WIDTH (localparam) = DATA_WIDTH + $clog2(PIX_PER_MAP); the signed sum cannot overflow
// PORTS
//  clk        in   1                     clock, all logic on posedge
//  rst_n      in   1                     asynchronous reset, active-low
//  clear      in   1                     synchronous frame abort
//  s_valid    in   1                     input beat valid
//  s_ready    out  1                     block accepts a beat
//  s_data     in   DATA_WIDTH x N_MATS   signed pixel, one per map ([k] -> class k)
//  sum        out  DATA_WIDTH x N_MATS   unsigned class scores, registered
//  out_valid  out  1                     sum[] holds a complete frame
//  out_ready  in   1                     downstream consumed sum[]
//  frame_err  out  1                     sticky flag: clear asserted mid-frame since reset
// BEHAVIOUR
//  Reset (rst_n=0, async): state=ACCUM, pix_cnt=0, all accumulators=0, sum[]=0,
//   out_valid=0, frame_err=0. s_ready=1 from the first clock after release.
//  States (typedef enum): ACCUM (s_ready=1, out_valid=0), HOLD (s_ready=0, out_valid=1).
//  ACCUM: on a beat (s_valid&&s_ready) acc[k] += sign-extend(s_data[k]) for every k.
//   pix_cnt increments on each beat.
//   On the beat with pix_cnt==PIX_PER_MAP-1: sum[k] <= clamp(acc[k]+s_data[k]),
//   acc<=0, pix_cnt<=0, state<=HOLD. out_valid rises the cycle after the last beat.
//   Latency from last beat to out_valid: 1 cycle.
//  HOLD: sum[] and out_valid stay stable until out_ready=1.
//   On that cycle, state<=ACCUM; s_ready=1 on the next cycle.
//   out_ready is ignored in ACCUM.
//  clamp: signed ACC_WIDTH -> unsigned DATA_WIDTH (ReLU + saturate).
//   <0 -> 0; >2^DATA_WIDTH-1 -> 2^DATA_WIDTH-1; otherwise truncate.
//   The downstream unsigned compare therefore orders scores correctly.
//  clear: highest priority after reset.
//   In ACCUM: acc<=0, pix_cnt<=0, and any beat in the same cycle is discarded.
//   If pix_cnt!=0, frame_err<=1.
//   In HOLD: out_valid<=0, state<=ACCUM, and sum[] keeps its last value.
//   frame_err clears only on reset.
//  No bubbles are required. A continuous s_valid stream is accepted at one beat per
//   cycle, except during HOLD (a minimum of 1 cycle per frame).
// CONFIGURATION
//  AVG_POOL_EN defined:
//   sum[k] = clamp(total >>> $clog2(PIX_PER_MAP)), a mean of floor type.
//   PIX_PER_MAP must be a power of 2; an elaboration-time $error fires otherwise.
//  AVG_POOL_EN undefined: sum[k] = clamp(total), i.e. a raw sum. Timing is identical.
// STRUCTURE
//  cnn_pkg:
//   acc_state_t enum {ACCUM, HOLD}
//   function clamp_u(signed ACC_WIDTH) -> DATA_WIDTH
//   N_CLASSES_DEFAULT=10
//  Sub-module class_sum_lane: one acc register, add, shift/clamp.
//   Controlled by beat/last/clear strobes from the top.
//   Generated N_MATS times.
//  Top level: FSM, pix_cnt ($clog2(PIX_PER_MAP) bits), handshake, frame_err.
// TESTING
//  1. Reset, then 16 beats with s_data[k]=k+1 and out_ready=0.
//     -> out_valid rises 1 cycle after beat 16.
//     -> sum[k]=16*(k+1), or (k+1) with AVG_POOL_EN.
//     -> s_ready=0 while HOLD; after 10 idle cycles sum[] is unchanged.
//  2. Lane 3 gets 0x7FFF for all beats; others get 0x8000.
//     -> sum[3]=0xFFFF (saturated) or 0x7FFF (AVG); others 0 (ReLU).
//  3. Back-to-back frames with s_valid held at 1 and out_ready=1.
//     -> each frame takes 17 cycles; no beat lost or duplicated.
//     -> second frame's sums are independent of the first.
//  4. clear after beat 7 of a frame.
//     -> frame_err=1, and the next 16 beats produce correct sums with no carry-over.
//     -> clear during HOLD drops out_valid next cycle.
//  5. rst_n pulsed low mid-frame (beat 9) and mid-HOLD.
//     -> outputs go to reset values immediately (async), with no clock edge needed.
//     -> the next full frame is correct.
//  6. Random s_valid/out_ready throttling over 200 frames vs. a reference model.
//     -> all sums match; sum[] stays stable while out_valid && !out_ready.

Source files
------------

// File: rtl/class_sum_accumulator_pkg.sv
// cnn_pkg: state type, default class count and ReLU/saturate helper
// shared by the class_sum_accumulator slice.
package cnn_pkg;

    localparam int N_CLASSES_DEFAULT = 10;

    typedef enum logic {
        ACCUM,
        HOLD
    } acc_state_t;

    // Signed value -> unsigned dw-bit score: negative to 0, saturate high.
    function automatic logic [63:0] clamp_u(
        input logic signed [63:0] v,
        input int                 dw
    );
        logic [63:0] top;
        top = (64'd1 << dw) - 64'd1;
        if (v < 0) return '0;
        if ($unsigned(v) > top) return top;
        return $unsigned(v);
    endfunction

endpackage

// File: rtl/class_sum_accumulator_if.sv
// Stream-in / scores-out bundle of class_sum_accumulator.
// master = feeder + consumer side, slave = accumulator.
interface class_sum_accumulator_if
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int N_MATS     = N_CLASSES_DEFAULT
);
    logic                               clear;
    logic                               s_valid;
    logic                               s_ready;
    logic [N_MATS-1:0][DATA_WIDTH-1:0]  s_data;
    logic [N_MATS-1:0][DATA_WIDTH-1:0]  sum;
    logic                               out_valid;
    logic                               out_ready;
    logic                               frame_err;

    modport master (
        output clear, s_valid, s_data, out_ready,
        input  s_ready, sum, out_valid, frame_err
    );

    modport slave (
        input  clear, s_valid, s_data, out_ready,
        output s_ready, sum, out_valid, frame_err
    );
endinterface

// File: rtl/class_sum_accumulator_lane.sv
// One class lane: running signed sum, then pool/clamp into a score.
// AVG_POOL_EN selects the floor mean instead of the raw sum.
module class_sum_lane
    import cnn_pkg::*;
#(
    parameter int DW  = 16,
    parameter int PIX = 16,
    parameter int AW  = DW + $clog2(PIX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          beat,
    input  logic          last,
    input  logic          clear,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] sum
);
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] total;
    logic signed [AW-1:0] pooled;
    logic signed [63:0]   wide;
    logic        [DW-1:0] score;

    assign total = acc + {{(AW-DW){data[DW-1]}}, data};

`ifdef AVG_POOL_EN
    localparam int SH = $clog2(PIX);
    assign pooled = total >>> SH;
`else
    assign pooled = total;
`endif

    assign wide  = {{(64-AW){pooled[AW-1]}}, pooled};
    assign score = DW'(clamp_u(wide, DW));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            sum <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (beat) begin
            if (last) begin
                acc <= '0;
                sum <= score;
            end else begin
                acc <= total;
            end
        end
    end
endmodule

// File: rtl/class_sum_accumulator.sv
// Per-class pixel sum/mean reducer feeding the class max comparator.
// Optional feature macro: AVG_POOL_EN (floor mean instead of raw sum).
module class_sum_accumulator
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int N_MATS      = N_CLASSES_DEFAULT,
    parameter int PIX_PER_MAP = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    class_sum_accumulator_if.slave bus
);
    localparam int ACC_WIDTH = DATA_WIDTH + $clog2(PIX_PER_MAP);
    localparam int CW        = $clog2(PIX_PER_MAP);

    if (PIX_PER_MAP < 2) begin : g_bad_pix
        $error("PIX_PER_MAP must be >= 2");
    end
`ifdef AVG_POOL_EN
    if ((PIX_PER_MAP & (PIX_PER_MAP - 1)) != 0) begin : g_bad_pow2
        $error("AVG_POOL_EN needs PIX_PER_MAP to be a power of 2");
    end
`endif

    acc_state_t                        state;
    logic [CW-1:0]                     pix_cnt;
    logic                              ready_q;
    logic                              valid_q;
    logic                              err_q;
    logic                              beat;
    logic                              last;
    logic [N_MATS-1:0][DATA_WIDTH-1:0] sums;

    // ready_q is only ever set while in ACCUM, so it alone gates a beat.
    assign beat = bus.s_valid && ready_q && !bus.clear;
    assign last = (pix_cnt == CW'(PIX_PER_MAP - 1));

    assign bus.s_ready   = ready_q;
    assign bus.out_valid = valid_q;
    assign bus.frame_err = err_q;
    assign bus.sum       = sums;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACCUM;
            pix_cnt <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (bus.clear) begin
            if (state == ACCUM && pix_cnt != '0) err_q <= 1'b1;
            pix_cnt <= '0;
            state   <= ACCUM;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            unique case (state)
                ACCUM: begin
                    ready_q <= 1'b1;
                    if (beat) begin
                        if (last) begin
                            pix_cnt <= '0;
                            state   <= HOLD;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                        end else begin
                            pix_cnt <= pix_cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state   <= ACCUM;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    for (genvar k = 0; k < N_MATS; k++) begin : g_lane
        class_sum_lane #(
            .DW  (DATA_WIDTH),
            .PIX (PIX_PER_MAP),
            .AW  (ACC_WIDTH)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .beat  (beat),
            .last  (last),
            .clear (bus.clear),
            .data  (bus.s_data[k]),
            .sum   (sums[k])
        );
    end
endmodule

// File: tb/tb_class_sum_accumulator.sv
// Randomized self-checking bench for class_sum_accumulator,
// scored against a per-frame arithmetic model of the class scores.
module tb_class_sum_accumulator;
    localparam int DW = 16;
    localparam int N  = 10;
    localparam int P  = 16;

    typedef logic [N-1:0][DW-1:0] vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    longint tot [N];

    class_sum_accumulator_if #(.DATA_WIDTH(DW), .N_MATS(N)) bus ();

    class_sum_accumulator #(
        .DATA_WIDTH  (DW),
        .N_MATS      (N),
        .PIX_PER_MAP (P)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] score(input longint t_in);
        longint t;
        t = t_in;
`ifdef AVG_POOL_EN
        t = t >>> $clog2(P);
`endif
        if (t < 0) return '0;
        if (t > 65535) return 16'hFFFF;
        return t[DW-1:0];
    endfunction

    function automatic vec_t model_result();
        vec_t r;
        for (int k = 0; k < N; k++) r[k] = score(tot[k]);
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int k = 0; k < N; k++) v[k] = 16'($urandom);
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N; k++) tot[k] = 0;
    endtask

    task automatic model_add(input vec_t d);
        for (int k = 0; k < N; k++) tot[k] += longint'($signed(d[k]));
    endtask

    // Called at a negedge; returns at the negedge after the beat is taken.
    task automatic push_beat(input vec_t d, output bit ok);
        int n;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        while (bus.s_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.s_ready === 1'b1);
        if (ok) model_add(d);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic send_random_frame(output bit ok);
        bit o;
        ok = 1'b1;
        model_clear();
        for (int b = 0; b < P; b++) begin
            push_beat(rand_vec(), o);
            ok &= o;
        end
    endtask

    task automatic release_hold();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b exp 0", bus.out_valid);
        end
        checks++;
        if (bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_err got %b exp 0", bus.frame_err);
        end
        checks++;
        if (bus.sum !== '0) begin
            errors++;
            $display("FAIL reset_sum got %h exp 0", bus.sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_s_ready got %b exp 1", bus.s_ready);
        end
    endtask

    task automatic test_ramp();
        vec_t d, exp_v, held;
        bit ok, o;
        ok = 1'b1;
        model_clear();
        for (int k = 0; k < N; k++) d[k] = DW'(k + 1);
        for (int b = 0; b < P; b++) begin
            if (b == P - 1) begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL ramp_early_valid got %b exp 0", bus.out_valid);
                end
            end
            push_beat(d, o);
            ok &= o;
        end
        exp_v = model_result();
        checks++;
        if (!ok || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ramp_valid got %b exp 1 (accepted=%b)", bus.out_valid, ok);
        end
        checks++;
        if (bus.sum !== exp_v) begin
            errors++;
            $display("FAIL ramp_sum got %h exp %h", bus.sum, exp_v);
        end
        checks++;
        if (bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL ramp_hold_ready got %b exp 0", bus.s_ready);
        end
        held = bus.sum;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.sum !== exp_v || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ramp_hold_stable got %h/%b exp %h/1", bus.sum, bus.out_valid, held);
        end
        release_hold();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL ramp_release got v=%b r=%b exp v=0 r=1", bus.out_valid, bus.s_ready);
        end
    endtask

    task automatic test_saturate();
        vec_t d, exp_v;
        bit ok, o;
        ok = 1'b1;
        model_clear();
        for (int k = 0; k < N; k++) d[k] = (k == 3) ? 16'h7FFF : 16'h8000;
        for (int b = 0; b < P; b++) begin
            push_beat(d, o);
            ok &= o;
        end
        exp_v = model_result();
        checks++;
        if (!ok || bus.sum !== exp_v) begin
            errors++;
            $display("FAIL sat_sum got %h exp %h (accepted=%b)", bus.sum, exp_v, ok);
        end
        release_hold();
    endtask

    task automatic test_back_to_back();
        vec_t exp_v;
        bit ok;
        int prev;
        prev = 0;
        bus.out_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            send_random_frame(ok);
            exp_v = model_result();
            checks++;
            if (!ok || bus.out_valid !== 1'b1 || bus.sum !== exp_v) begin
                errors++;
                $display("FAIL b2b_sum f=%0d got %h/%b exp %h/1", f, bus.sum, bus.out_valid, exp_v);
            end
            if (f > 0) begin
                checks++;
                if (cyc - prev != P + 1) begin
                    errors++;
                    $display("FAIL b2b_period f=%0d got %0d exp %0d", f, cyc - prev, P + 1);
                end
            end
            prev = cyc;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_clear();
        vec_t exp_v, held;
        bit ok, o;
        checks++;
        if (bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL clear_err_pre got %b exp 0", bus.frame_err);
        end
        for (int b = 0; b < 7; b++) push_beat(rand_vec(), o);
        bus.clear   = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = rand_vec();
        @(negedge clk);
        bus.clear   = 1'b0;
        bus.s_valid = 1'b0;
        checks++;
        if (bus.frame_err !== 1'b1) begin
            errors++;
            $display("FAIL clear_err got %b exp 1", bus.frame_err);
        end
        send_random_frame(ok);
        exp_v = model_result();
        checks++;
        if (!ok || bus.out_valid !== 1'b1 || bus.sum !== exp_v) begin
            errors++;
            $display("FAIL clear_next_sum got %h/%b exp %h/1", bus.sum, bus.out_valid, exp_v);
        end
        held = bus.sum;
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.s_ready !== 1'b1 || bus.sum !== held) begin
            errors++;
            $display("FAIL clear_hold got v=%b r=%b s=%h exp v=0 r=1 s=%h",
                     bus.out_valid, bus.s_ready, bus.sum, held);
        end
    endtask

    task automatic test_async_reset();
        vec_t exp_v;
        bit ok, o;
        for (int b = 0; b < 9; b++) push_beat(rand_vec(), o);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.sum !== '0) begin
            errors++;
            $display("FAIL arst_mid_frame got v=%b e=%b s=%h exp 0/0/0",
                     bus.out_valid, bus.frame_err, bus.sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_random_frame(ok);
        exp_v = model_result();
        checks++;
        if (!ok || bus.out_valid !== 1'b1 || bus.sum !== exp_v) begin
            errors++;
            $display("FAIL arst_frame1 got %h/%b exp %h/1", bus.sum, bus.out_valid, exp_v);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.sum !== '0) begin
            errors++;
            $display("FAIL arst_hold got v=%b s=%h exp 0/0", bus.out_valid, bus.sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_random_frame(ok);
        exp_v = model_result();
        checks++;
        if (!ok || bus.out_valid !== 1'b1 || bus.sum !== exp_v) begin
            errors++;
            $display("FAIL arst_frame2 got %h/%b exp %h/1", bus.sum, bus.out_valid, exp_v);
        end
        release_hold();
    endtask

    task automatic test_random();
        vec_t exp_q [$];
        vec_t last_sum;
        bit   held, sv, orr;
        int   frames, beats;
        frames = 0;
        beats  = 0;
        held   = 1'b0;
        last_sum = '0;
        model_clear();
        for (int c = 0; c < 60000 && frames < 200; c++) begin
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious got valid with %h exp no frame", bus.sum);
                end else if (bus.sum !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rand_sum frame=%0d got %h exp %h", frames, bus.sum, exp_q[0]);
                end
                if (held) begin
                    checks++;
                    if (bus.sum !== last_sum) begin
                        errors++;
                        $display("FAIL rand_stable got %h exp %h", bus.sum, last_sum);
                    end
                end
            end
            sv  = ($urandom_range(3, 0) != 0);
            orr = 1'($urandom_range(1, 0));
            bus.s_valid   = sv;
            bus.s_data    = rand_vec();
            bus.out_ready = orr;
            if (sv && bus.s_ready === 1'b1) begin
                model_add(bus.s_data);
                beats++;
                if (beats == P) begin
                    exp_q.push_back(model_result());
                    model_clear();
                    beats = 0;
                end
            end
            if (bus.out_valid === 1'b1 && orr) begin
                if (exp_q.size() > 0) exp_q.delete(0);
                frames++;
                held = 1'b0;
            end else begin
                held = (bus.out_valid === 1'b1);
            end
            last_sum = bus.sum;
            @(negedge clk);
        end
        checks++;
        if (frames != 200) begin
            errors++;
            $display("FAIL rand_timeout got %0d frames exp 200", frames);
        end
        bus.s_valid   = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.clear     = 1'b0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_ramp();
        test_saturate();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
